// File: rtl/jtframe_pkg.sv
// Shared JTFRAME definitions: boot sequencer states and the default timing
// constants used by every board target.
package jtframe_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_SDINIT,
    ST_HOLD,
    ST_RUN
  } boot_st_t;

  localparam int BOOT_LOCK_CNT = 1024;
  localparam int BOOT_SDRAM_TO = 65536;
  localparam int BOOT_RST_HOLD = 256;

  // Largest of three timer lengths, used to size the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Generic two-flop synchroniser for a single asynchronous status bit.
module jtframe_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two back-to-back flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/jtframe_boot_seq.sv
// Power-up / recovery sequencer: PLL lock qualification, SDRAM init request,
// minimum game reset hold, then release.
//
//  state        | meaning
//  -------------+-------------------------------------------------------
//  ST_WAIT_LOCK | game held in reset, waiting for synchronised PLL lock
//  ST_STABLE    | lock seen, counting LOCK_CNT cycles of continuous lock
//  ST_SDINIT    | SDRAM init requested, waiting for done or timeout
//  ST_HOLD      | SDRAM ready, holding game reset for RST_HOLD cycles
//  ST_RUN       | reset released, game running
module jtframe_boot_seq
  import jtframe_pkg::*;
#(
  parameter int LOCK_CNT = BOOT_LOCK_CNT,
  parameter int SDRAM_TO = BOOT_SDRAM_TO,
  parameter int RST_HOLD = BOOT_RST_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       user_rst,
  input  logic       downloading,
  output logic       game_rst,
  output logic       sdram_init,
  output logic       ready,
  output logic       init_err,
  output logic [7:0] lock_lost
);

  localparam int CW = $clog2(max3(LOCK_CNT, SDRAM_TO, RST_HOLD));
  localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] SD_LD   = CW'(SDRAM_TO - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(RST_HOLD - 1);

  boot_st_t      st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic [7:0]    lost_nxt;
  logic          lock_s;
  logic          cnt_zero;
  logic          hold_req;

  jtframe_sync2 u_lock_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pll_locked),
    .dout (lock_s)
  );

  // Next-state, counter reload and sticky status; lock loss overrides all.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    err_nxt  = init_err;
    lost_nxt = lock_lost;
    cnt_zero = (cnt == '0);
    hold_req = user_rst | downloading;
    if (st != ST_WAIT_LOCK && !lock_s) begin
      st_nxt  = ST_WAIT_LOCK;
      cnt_nxt = '0;
      if (st == ST_RUN && lock_lost != 8'hff) lost_nxt = lock_lost + 8'd1;
    end else begin
      case (st)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            st_nxt  = ST_STABLE;
            cnt_nxt = LOCK_LD;
          end
        end
        ST_STABLE: begin
          if (cnt_zero) begin
            st_nxt  = ST_SDINIT;
            cnt_nxt = SD_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_SDINIT: begin
          // done wins over a simultaneous timeout
          if (sdram_init_done) begin
            st_nxt  = ST_HOLD;
            cnt_nxt = HOLD_LD;
          end else if (cnt_zero) begin
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_req) begin
            cnt_nxt = HOLD_LD;
          end else if (cnt_zero) begin
            st_nxt  = ST_RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (hold_req) begin
            st_nxt  = ST_HOLD;
            cnt_nxt = HOLD_LD;
          end
        end
        default: begin
          st_nxt  = ST_WAIT_LOCK;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // State register; outputs are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_WAIT_LOCK;
      cnt        <= '0;
      game_rst   <= 1'b1;
      sdram_init <= 1'b0;
      ready      <= 1'b0;
      init_err   <= 1'b0;
      lock_lost  <= 8'd0;
    end else begin
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      game_rst   <= (st_nxt != ST_RUN);
      sdram_init <= (st_nxt == ST_SDINIT);
      ready      <= (st_nxt == ST_RUN);
      init_err   <= err_nxt;
      lock_lost  <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_jtframe_boot_seq.sv
// Self-checking bench for jtframe_boot_seq: directed vector table, hand
// sequences for multi-cycle corners, and a random run against a phase/age
// reference model.
module tb_jtframe_boot_seq;

  localparam int LOCK_CNT = 16;
  localparam int SDRAM_TO = 32;
  localparam int RST_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst, pll_locked, sdram_init_done, user_rst, downloading;
  logic       game_rst, sdram_init, ready, init_err;
  logic [7:0] lock_lost;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  jtframe_boot_seq #(
    .LOCK_CNT (LOCK_CNT),
    .SDRAM_TO (SDRAM_TO),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .user_rst        (user_rst),
    .downloading     (downloading),
    .game_rst        (game_rst),
    .sdram_init      (sdram_init),
    .ready           (ready),
    .init_err        (init_err),
    .lock_lost       (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with an up-counting age, lock seen two edges late.
  localparam int P_WAIT = 0, P_STABLE = 1, P_SD = 2, P_HOLD = 3, P_RUN = 4;
  int         m_ph = P_WAIT;
  int         m_age = 0;
  bit [1:0]   m_sync = 2'b00;
  bit         m_err = 1'b0;
  int         m_lost = 0;

  always @(posedge clk) begin
    bit ls;
    int nxt;
    ls = m_sync[1];
    m_sync = {m_sync[0], pll_locked};
    if (rst) begin
      m_ph = P_WAIT; m_age = 0; m_sync = 2'b00; m_err = 1'b0; m_lost = 0;
    end else begin
      m_age++;
      nxt = m_ph;
      if (m_ph != P_WAIT && !ls) begin
        if (m_ph == P_RUN && m_lost < 255) m_lost++;
        nxt = P_WAIT;
      end else begin
        case (m_ph)
          P_WAIT:   if (ls) nxt = P_STABLE;
          P_STABLE: if (m_age >= LOCK_CNT) nxt = P_SD;
          P_SD: begin
            if (sdram_init_done) nxt = P_HOLD;
            else if (m_age >= SDRAM_TO) begin m_err = 1'b1; nxt = P_WAIT; end
          end
          P_HOLD: begin
            if (user_rst || downloading) m_age = 0;
            else if (m_age >= RST_HOLD) nxt = P_RUN;
          end
          default:  if (user_rst || downloading) nxt = P_HOLD;
        endcase
      end
      if (nxt != m_ph) m_age = 0;
      m_ph = nxt;
    end
  end

  // Compare every cycle against the model once it has seen a reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_game_rst",   int'(game_rst),   int'(m_ph != P_RUN));
      check("mdl_sdram_init", int'(sdram_init), int'(m_ph == P_SD));
      check("mdl_ready",      int'(ready),      int'(m_ph == P_RUN));
      check("mdl_init_err",   int'(init_err),   int'(m_err));
      check("mdl_lock_lost",  int'(lock_lost),  m_lost);
    end
  end

  typedef struct {
    bit         rst, pll, done, urst, dl;
    int         n;
    bit         grst, sdi, rdy, err;
    logic [7:0] lost;
  } vec_t;

  vec_t vec[25];

  initial begin
    int k;
    rst = 1'b1; pll_locked = 1'b0; sdram_init_done = 1'b0;
    user_rst = 1'b0; downloading = 1'b0;

    //              rst   pll   done  urst  dl    n    grst  sdi   rdy   err   lost
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,   2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  15, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,   2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vec[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,   3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vec[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  18, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vec[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vec[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  31, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vec[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    vec[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    vec[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  15, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    vec[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
    vec[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    vec[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   4, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    vec[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      rst = vec[i].rst; pll_locked = vec[i].pll; sdram_init_done = vec[i].done;
      user_rst = vec[i].urst; downloading = vec[i].dl;
      repeat (vec[i].n) @(negedge clk);
      check($sformatf("vec%0d_game_rst", i),   int'(game_rst),   int'(vec[i].grst));
      check($sformatf("vec%0d_sdram_init", i), int'(sdram_init), int'(vec[i].sdi));
      check($sformatf("vec%0d_ready", i),      int'(ready),      int'(vec[i].rdy));
      check($sformatf("vec%0d_init_err", i),   int'(init_err),   int'(vec[i].err));
      check($sformatf("vec%0d_lock_lost", i),  int'(lock_lost),  int'(vec[i].lost));
      if (i == 0) chk_en = 1'b1;
    end

    // Glitchy lock: one low cycle restarts the stability count.
    pll_locked = 1'b1;
    repeat (10) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    k = 0;
    while (!sdram_init && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("glitch_sdram_init_delay", k, LOCK_CNT + 3);
    check("glitch_lock_lost", int'(lock_lost), 0);

    // Repeated lock loss from RUN coinciding with user reset at the sync output.
    sdram_init_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = 0;
      while (!ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) begin
        check("loop_ready_timeout", k, 0);
        break;
      end
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      user_rst = 1'b1;
      @(negedge clk);
      user_rst = 1'b0;
      pll_locked = 1'b1;
      if (i == 0) begin
        check("loss_game_rst", int'(game_rst), 1);
        check("loss_lock_lost_first", int'(lock_lost), 1);
      end
    end
    check("loss_lock_lost_sat", int'(lock_lost), 255);
    sdram_init_done = 1'b0;

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      rst             = ($urandom_range(0, 599) == 0);
      pll_locked      = ($urandom_range(0, 79) != 0);
      sdram_init_done = ($urandom_range(0, 39) == 0);
      user_rst        = ($urandom_range(0, 59) == 0);
      downloading     = ($urandom_range(0, 99) < 2);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtframe_boot_seq.md
# jtframe_boot_seq

Power-up and recovery sequencer for the JTFRAME clock/reset subsystem. It watches the game PLL lock and waits for the lock to be stable. It then requests SDRAM initialisation, holds the game in reset for a minimum time, and finally releases `game_rst`, which feeds the per-domain reset synchronisers. Any loss of lock, user reset or ROM download sends the sequence back to the correct earlier state.

## Interface

Parameters:
- `LOCK_CNT`, 1024: cycles `pll_locked` must stay high before SDRAM init starts; ≥2.
- `SDRAM_TO`, 65536: maximum cycles to wait for `sdram_init_done`.
- `RST_HOLD`, 256: minimum cycles `game_rst` stays asserted after SDRAM is ready; ≥1.

Ports:
- `clk`, in, 1: sequencer clock, free-running reference (27 MHz domain).
- `rst`, in, 1: synchronous active-high reset. One clock; reset is synchronous and active-high.
- `pll_locked`, in, 1: PLL lock, asynchronous; synchronised internally.
- `sdram_init_done`, in, 1: level; high once the SDRAM controller has finished init. Synchronous to `clk`.
- `user_rst`, in, 1: OSD/button reset, level, synchronous.
- `downloading`, in, 1: ROM download active, level, synchronous.
- `game_rst`, out, 1: reset request to the clock-domain synchronisers.
- `sdram_init`, out, 1: SDRAM init request, level.
- `ready`, out, 1: sequence complete, game running.
- `init_err`, out, 1: sticky; the SDRAM init timed out at least once.
- `lock_lost`, out, 8: saturating count of lock losses seen after reaching `RUN`.

## Operation

- Lock input: two-flop synchroniser produces `lock_s`.
- Counter: one shared down-counter `cnt`, width `$clog2(max(LOCK_CNT,SDRAM_TO,RST_HOLD))`. It is reloaded on every state entry.
- States: `WAIT_LOCK`, `STABLE`, `SDINIT`, `HOLD`, `RUN`.
- `WAIT_LOCK`:
  - `game_rst`=1, `sdram_init`=0, `ready`=0.
  - When `lock_s`=1: load `LOCK_CNT-1`, go to `STABLE`.
- `STABLE`:
  - Decrement `cnt` each cycle.
  - At `cnt`==0 with `lock_s`=1: load `SDRAM_TO-1`, go to `SDINIT`.
- `SDINIT`:
  - `sdram_init`=1.
  - When `sdram_init_done`=1: load `RST_HOLD-1`, go to `HOLD`.
  - At `cnt`==0 without done: set `init_err`, go to `WAIT_LOCK`. This retries the full sequence.
- `HOLD`:
  - `game_rst`=1, `sdram_init`=0.
  - Decrement `cnt`. If `user_rst` or `downloading` is high, reload `RST_HOLD-1` instead.
  - At `cnt`==0 with both low: go to `RUN`.
- `RUN`:
  - `game_rst`=0, `ready`=1.
  - When `user_rst` or `downloading` is high: load `RST_HOLD-1`, go to `HOLD`. SDRAM is not re-initialised.
- Lock loss has the highest priority in every state. `lock_s`=0 in any state other than `WAIT_LOCK` means go to `WAIT_LOCK`. `lock_lost` increments only when leaving `RUN` this way, and saturates at 255.
- Simultaneous events:
  - Lock loss together with `user_rst`/`downloading`: go to `WAIT_LOCK`.
  - `sdram_init_done` on the same cycle as timeout (`cnt`==0): done wins, go to `HOLD`.
- Reset values: state `WAIT_LOCK`, `game_rst`=1, `sdram_init`=0, `ready`=0, `init_err`=0, `lock_lost`=0, `cnt`=0, synchroniser flops 0.
- `rst` mid-sequence returns to reset values on the next edge. Sticky status is cleared only by `rst`.

## Timing

- `pll_locked` rise to `STABLE` entry: 3 cycles (2 for sync, 1 for the state register).
- `STABLE` lasts exactly `LOCK_CNT` cycles when lock holds, so `sdram_init` rises `LOCK_CNT`+3 cycles after `pll_locked`.
- `sdram_init_done` high to `sdram_init` low: 1 cycle.
- `HOLD` lasts exactly `RST_HOLD` cycles after the last cycle with `user_rst`/`downloading` high. `game_rst` falls and `ready` rises on the same edge.
- `pll_locked` fall to `game_rst`=1: 3 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure

- Shared `jtframe_pkg`: state enum `boot_st_t`; the default constants for `LOCK_CNT`, `SDRAM_TO` and `RST_HOLD`, so that MiST, Neptuno and MiSTer targets use the same values.
- Sub-module `jtframe_sync2`: a generic two-flop bit synchroniser, reusable for other asynchronous status inputs. Everything else stays in one FSM module.
- Instantiation: next to `jtframe_mist_clocks`.
  - `game_rst` drives that block's reset input.
  - `pll_locked` comes from its lock output.

## Test plan

- Clean boot (`LOCK_CNT`=16, `RST_HOLD`=8): assert `pll_locked` at cycle 10 and return `sdram_init_done` 5 cycles after `sdram_init` rises. Expect `sdram_init` high at cycle 29 and `game_rst` low / `ready` high exactly 8 cycles after done is seen.
- Glitchy lock: `pll_locked` high for 10 cycles, low for 1, then high. Expect the counter to restart, `sdram_init` to rise 16+3 cycles after the final rise, and `lock_lost` to stay 0.
- Timeout (`SDRAM_TO`=32): never assert done. Expect `init_err`=1 and `sdram_init` low after 32 cycles, then a second `STABLE`/`SDINIT` pass.
- In `RUN`, pulse `downloading` for 100 cycles. Expect `game_rst`=1 throughout and released exactly 8 cycles after `downloading` falls, with no new `sdram_init`.
- In `RUN`, drop `pll_locked` on the same cycle as `user_rst`. Expect `WAIT_LOCK`, `game_rst`=1 within 3 cycles, and `lock_lost`=1. Repeat 300 times and expect `lock_lost`=255.
- Assert `rst` for 1 cycle during `HOLD` with `init_err`=1. Expect all outputs at their reset values on the next cycle.
